// File: rtl/instruction_loader.sv
// Byte-stream loader: packs big-endian bytes into words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to add a trailing XOR check byte and the CHECK state.
module instruction_loader #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_we,
    output logic [NB_ADDR-1:0] o_addr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_full,
    output logic [NB_ADDR-2:0] o_word_count,
    output logic               o_error
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
`ifdef LOADER_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t             state;
    state_t             state_next;
    logic [NB_ADDR-1:0] addr;
    logic [1:0]         byte_cnt;
    logic [NB_DATA-1:0] shift;
    logic               start_ok;
    logic               last_write;

    assign start_ok   = i_start && (state == IDLE || state == DONE);
    // The terminating decision is made on the write cycle itself.
    assign last_write = o_we && (o_data == HALT_WORD || addr == LAST_ADDR);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (i_start)    state_next = LOAD;
            LOAD:       if (last_write) state_next = END_STATE;
`ifdef LOADER_CHECKSUM_EN
            CHECK:      if (i_rx_valid) state_next = DONE;
`endif
            default:    state_next = IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    assign o_busy = (state == LOAD) || (state == CHECK);
`else
    assign o_busy = (state == LOAD);
`endif
    assign o_done = (state == DONE);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            addr         <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            o_we         <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_full       <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_we <= 1'b0;
            if (start_ok) begin
                addr         <= '0;
                byte_cnt     <= '0;
                shift        <= '0;
                o_full       <= 1'b0;
                o_word_count <= '0;
            end
            if (state == LOAD) begin
                if (o_we) begin
                    o_word_count <= o_word_count + 1'b1;
                    if (addr != LAST_ADDR)
                        addr <= addr + NB_ADDR'(4);
                    else if (o_data != HALT_WORD)
                        o_full <= 1'b1;
                end
                if (i_rx_valid) begin
                    shift    <= {shift[NB_DATA-9:0], i_rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        o_we   <= 1'b1;
                        o_data <= {shift[NB_DATA-9:0], i_rx_data};
                        o_addr <= addr;
                    end
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            csum    <= '0;
            o_error <= 1'b0;
        end else begin
            if (start_ok) begin
                csum    <= '0;
                o_error <= 1'b0;
            end
            if (state == LOAD && i_rx_valid)
                csum <= csum ^ i_rx_data;
            if (state == CHECK && i_rx_valid && i_rx_data != csum)
                o_error <= 1'b1;
        end
    end
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader; reference model works on whole
// bytes/words and predicts every memory write (address, data, cycle) plus status levels.
module tb_instruction_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_we;
    logic [7:0]  o_addr;
    logic [31:0] o_data;
    logic        o_busy;
    logic        o_done;
    logic        o_full;
    logic [6:0]  o_word_count;
    logic        o_error;

    instruction_loader dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_we         (o_we),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_full       (o_full),
        .o_word_count (o_word_count),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // reference model state
    bit          m_active = 0;
    bit          m_check = 0;
    bit          m_done = 0;
    bit          m_full = 0;
    bit          m_err = 0;
    int          m_addr = 0;
    int          m_nbytes = 0;
    int          m_wc = 0;
    logic [31:0] m_word = 0;
    logic [7:0]  m_xor = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!i_rst && o_we) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(o_addr), 32'(e.addr));
                chk("write_data", o_data, e.data);
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit term;
        term = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        if (m_check) begin
            m_err   = (b != m_xor);
            m_check = 0;
            m_done  = 1;
            idle(2);
        end else if (m_active) begin
            m_xor    = m_xor ^ b;
            m_word   = {m_word[23:0], b};
            m_nbytes = m_nbytes + 1;
            if (m_nbytes % 4 == 0) begin
                exp_q.push_back('{addr: 8'(m_addr), data: m_word, cyc: cyc});
                m_wc = m_wc + 1;
                term = (m_word == HALT) || (m_addr == 252);
                if (m_addr == 252 && m_word != HALT) m_full = 1;
                if (!term) m_addr = m_addr + 4;
            end
            if (term) begin
                m_active = 0;
`ifdef LOADER_CHECKSUM_EN
                m_check = 1;
`else
                m_done = 1;
`endif
                idle(3);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    // sends the trailing check byte in the checksum build (deliberately wrong if bad)
    task automatic end_load(input bit bad);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = m_xor ^ {7'd0, bad};
        send_byte(c);
`else
        if (bad) idle(1);
`endif
    endtask

    task automatic start_load();
        bit accept;
        accept = !m_active && !m_check;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        if (accept) begin
            m_active = 1; m_done = 0; m_full = 0; m_err = 0;
            m_addr = 0; m_nbytes = 0; m_wc = 0; m_word = 0; m_xor = 0;
            chk("busy_after_start", 32'(o_busy), 32'd1);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'(m_active || m_check));
        chk({tag, "_done"}, 32'(o_done), 32'(m_done));
        chk({tag, "_full"}, 32'(o_full), 32'(m_full));
        chk({tag, "_word_count"}, 32'(o_word_count), 32'(m_wc));
        chk({tag, "_error"}, 32'(o_error), 32'(m_err));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"}, 32'(o_we), 32'd0);
        chk({tag, "_addr"}, 32'(o_addr), 32'd0);
        chk({tag, "_data"}, o_data, 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_full"}, 32'(o_full), 32'd0);
        chk({tag, "_word_count"}, 32'(o_word_count), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        return {8'($urandom_range(0, 254)), 24'($urandom)};
    endfunction

    initial begin
        idle(3);
        check_reset("reset");
        i_rst = 1'b0;
        idle(2);

        // bytes before any start are ignored
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        check_status("pre_start");

        // directed program
        start_load();
        send_word(32'h2008_0005, 1);
        send_word(HALT, 1);
        end_load(0);
        check_status("directed");

        // bytes after done are ignored
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        check_status("post_done");

        // back-to-back bytes, one per cycle
        start_load();
        for (int w = 0; w < 8; w++) send_word(rand_word(), 0);
        send_word(HALT, 0);
        end_load(1);
        check_status("burst");

        // start pulsed mid-load has no effect
        start_load();
        send_word(rand_word(), 2);
        send_byte(8'h12);
        start_load();
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        start_load();
        send_word(HALT, 2);
        end_load($urandom_range(0, 1));
        check_status("mid_start");

        // asynchronous reset after 6 bytes
        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        #2;
        i_rst = 1'b1;
        #1;
        check_reset("mid_reset");
        exp_q.delete();
        m_active = 0; m_check = 0; m_done = 0; m_full = 0; m_err = 0; m_wc = 0;
        idle(1);
        i_rst = 1'b0;
        idle(1);
        start_load();
        send_word(32'hA1B2_C3D4, 1);
        check_status("after_reset");
        send_word(HALT, 1);
        end_load(0);
        check_status("after_reset_end");

        // fill memory without HALT
        start_load();
        for (int w = 0; w < 64; w++) send_word(rand_word(), 1);
        end_load(0);
        check_status("full");
        send_word(rand_word(), 0);
        check_status("full_extra");

`ifdef LOADER_CHECKSUM_EN
        // documented checksum examples
        start_load();
        send_word(32'h0102_0304, 0);
        send_word(HALT, 0);
        send_byte(8'h04);
        check_status("csum_good");
        start_load();
        send_word(32'h0102_0304, 0);
        send_word(HALT, 0);
        send_byte(8'h05);
        check_status("csum_bad");
`endif

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            start_load();
            for (int w = 0, n = $urandom_range(1, 20); w < n; w++) begin
                if ($urandom_range(0, 7) == 0) send_word($urandom, 2);
                else send_word(rand_word(), 2);
                if (!m_active) break;
            end
            if (m_active) send_word(HALT, 2);
            end_load($urandom_range(0, 1));
            check_status("random");
        end

        idle(4);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
